// File: rtl/gbe_tx_arb_pkg.sv
// Shared types and defaults for the GbE transmit arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gbe_tx_arb_pkg;

  // Arbiter phases: waiting for a request, forwarding a packet,
  // discarding the tail of a truncated packet, enforcing the inter-packet gap.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  localparam int DEF_DIN_WIDTH = 128;
  localparam int DEF_LEN_WIDTH = 16;

endpackage

// File: rtl/gbe_tx_arbiter_rr_pick.sv
// Round-robin priority picker: first requester strictly after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; any=0 when nothing requests.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  // Scan ptr+1, ptr+2, ... ptr+N (mod N); the last candidate is ptr itself.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/gbe_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one GbE packetizer input among N_SRC sources.
// Latency: grant 1 cycle after an accepted request; dout/dout_valid/dout_eof 1 cycle behind the granted source.
// Backpressure: tx_afull and en only hold off new grants; a packet in flight always runs to its eof.
module gbe_tx_arbiter
  import gbe_tx_arb_pkg::*;
#(
  parameter int DIN_WIDTH = DEF_DIN_WIDTH,
  parameter int N_SRC     = 4,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_SRC-1:0]           src_req,
  output logic [N_SRC-1:0]           src_grant,
  input  logic [N_SRC*DIN_WIDTH-1:0] src_din,
  input  logic [N_SRC-1:0]           src_valid,
  input  logic [N_SRC-1:0]           src_eof,
  input  logic [31:0]                ifg_cycles,
  input  logic [LEN_WIDTH-1:0]       max_len,
  input  logic                       tx_afull,
  output logic [DIN_WIDTH-1:0]       dout,
  output logic                       dout_valid,
  output logic                       dout_eof,
  output logic [31:0]                pkt_count,
  output logic                       trunc_err,
  output logic                       busy
);

  localparam int IW = $clog2(N_SRC);

  arb_state_t           state, state_nxt;
  logic [IW-1:0]        ptr;
  logic [LEN_WIDTH-1:0] word_cnt, word_cnt_inc;
  logic [31:0]          gap_cnt;

  logic [N_SRC-1:0]     pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  logic                 g_valid, g_eof, max_hit, gap_done;
  logic [DIN_WIDTH-1:0] g_din;
  logic                 grant_ld, grant_clr, fwd, pkt_done, trunc_set;

  rr_pick #(.N(N_SRC), .IW(IW)) u_pick (
    .req (src_req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // ptr doubles as the index of the granted source while a packet is open.
  assign g_valid      = src_valid[ptr];
  assign g_eof        = src_eof[ptr];
  assign g_din        = src_din[int'(ptr) * DIN_WIDTH +: DIN_WIDTH];
  assign word_cnt_inc = word_cnt + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  assign max_hit      = (max_len != '0) && (word_cnt_inc == max_len);
  // gap_cnt counts GAP cycles already spent; ifg_cycles=0 still spends one.
  assign gap_done     = (gap_cnt + 32'd1) >= ifg_cycles;
  assign busy         = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle datapath strobes.
  always_comb begin
    state_nxt = state;
    grant_ld  = 1'b0;
    grant_clr = 1'b0;
    fwd       = 1'b0;
    pkt_done  = 1'b0;
    trunc_set = 1'b0;
    case (state)
      IDLE: begin
        if (en && !tx_afull && pick_any) begin
          grant_ld  = 1'b1;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (g_valid) begin
          fwd = 1'b1;
          if (g_eof) begin
            // eof wins over a coincident length limit: not a truncation
            pkt_done  = 1'b1;
            grant_clr = 1'b1;
            state_nxt = GAP;
          end else if (max_hit) begin
            pkt_done  = 1'b1;
            trunc_set = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (g_valid && g_eof) begin
          grant_clr = 1'b1;
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (gap_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered output path; dout holds its last value between words.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_eof   <= 1'b0;
    end else begin
      dout_valid <= fwd;
      dout_eof   <= fwd & (g_eof | max_hit);
      if (fwd) dout <= g_din;
    end
  end

  // Grant, pointer and per-packet counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      src_grant <= '0;
      ptr       <= IW'(N_SRC - 1);
      word_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      if (grant_ld) begin
        src_grant <= pick_gnt;
        ptr       <= pick_idx;
        word_cnt  <= '0;
      end else begin
        if (grant_clr) src_grant <= '0;
        if (fwd)       word_cnt  <= word_cnt_inc;
      end
      if (state == GAP) gap_cnt <= gap_cnt + 32'd1;
      else              gap_cnt <= '0;
    end
  end

  // Status: packets forwarded and sticky truncation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
      trunc_err <= 1'b0;
    end else begin
      if (pkt_done)  pkt_count <= pkt_count + 32'd1;
      if (trunc_set) trunc_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gbe_tx_arbiter.sv
// Bench for gbe_tx_arbiter: per-source packet stores, expected-word queue and round-robin rule.
// Inputs change and outputs are sampled on the falling clock edge.
// Sources stall randomly and non-granted sources inject noise on their valid lines.
module tb_gbe_tx_arbiter;

  localparam int DW    = 128;
  localparam int NS    = 4;
  localparam int LW    = 16;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst, en, tx_afull;
  logic [NS-1:0]    src_req, src_valid, src_eof, src_grant;
  logic [NS*DW-1:0] src_din;
  logic [31:0]      ifg_cycles, pkt_count;
  logic [LW-1:0]    max_len;
  logic [DW-1:0]    dout;
  logic             dout_valid, dout_eof, trunc_err, busy;

  always #5 clk = ~clk;

  gbe_tx_arbiter #(.DIN_WIDTH(DW), .N_SRC(NS), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst), .en(en), .src_req(src_req), .src_grant(src_grant),
    .src_din(src_din), .src_valid(src_valid), .src_eof(src_eof),
    .ifg_cycles(ifg_cycles), .max_len(max_len), .tx_afull(tx_afull),
    .dout(dout), .dout_valid(dout_valid), .dout_eof(dout_eof),
    .pkt_count(pkt_count), .trunc_err(trunc_err), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  logic [DW:0]   smem [NS][DEPTH];   // {eof, data} per source, in send order
  int            wp [NS];
  int            rp [NS];
  logic [DW:0]   exp_q [$];
  int            glog [$];
  logic [NS-1:0] prev_grant;
  bit            last_eof_pop [NS];
  int            last_k;
  logic [31:0]   exp_pkt;
  logic          exp_trunc;
  bit            noise_en, stall_en, rnd_ctl;
  int            vcnt;
  int            pid;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int first_bit(input logic [NS-1:0] v);
    for (int i = 0; i < NS; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rr_exp(input logic [NS-1:0] r, input int last);
    for (int i = 1; i <= NS; i++) if (r[(last + i) % NS]) return (last + i) % NS;
    return -1;
  endfunction

  function automatic bit all_empty();
    for (int i = 0; i < NS; i++) if (rp[i] != wp[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_pkt(input int s, input int len, input bit pat);
    logic [DW-1:0] d;
    for (int w = 0; w < len; w++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      d[DW-1 -: 8]  = 8'(s);
      d[DW-9 -: 8]  = 8'(pid);
      d[DW-17 -: 16] = 16'(w);
      if (pat) d = (w == 0) ? 128'haabbccdd : 128'(w);
      smem[s][wp[s]] = {(w == len - 1), d};
      wp[s]++;
    end
    pid++;
  endtask

  task automatic flush_model();
    for (int i = 0; i < NS; i++) begin
      rp[i] = wp[i];
      last_eof_pop[i] = 1'b0;
    end
    exp_q.delete();
    last_k    = NS - 1;
    exp_pkt   = '0;
    exp_trunc = 1'b0;
  endtask

  task automatic monitor();
    int k, pk, len, n;
    logic [DW:0] e;
    if (src_grant != '0 && prev_grant == '0) begin
      k = first_bit(src_grant);
      chk("grant_onehot", 128'($onehot(src_grant)), 128'(1));
      chk("grant_allowed", 128'(en && !tx_afull && (src_req != '0)), 128'(1));
      chk("rr_order", 128'(k), 128'(rr_exp(src_req, last_k)));
      last_k = k;
      glog.push_back(k);
      len = 0;
      while (rp[k] + len < wp[k] - 1 && !smem[k][rp[k] + len][DW]) len++;
      len++;
      n = (max_len != '0 && len > int'(max_len)) ? int'(max_len) : len;
      for (int w = 0; w < n; w++) begin
        e = smem[k][rp[k] + w];
        e[DW] = (w == n - 1);
        exp_q.push_back(e);
      end
      if (n < len) exp_trunc = 1'b1;
    end
    if (src_grant == '0 && prev_grant != '0) begin
      pk = first_bit(prev_grant);
      chk("release_on_eof", 128'(last_eof_pop[pk]), 128'(1));
    end
    if (dout_valid) begin
      vcnt++;
      if (exp_q.size() == 0) begin
        chk("stray_word", 128'(dout_valid), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("dout", dout, e[DW-1:0]);
        chk("dout_eof", 128'(dout_eof), 128'(e[DW]));
        if (e[DW]) begin
          exp_pkt++;
          chk("pkt_count", 128'(pkt_count), 128'(exp_pkt));
          chk("trunc_err", 128'(trunc_err), 128'(exp_trunc));
        end
      end
    end else begin
      chk("eof_without_valid", 128'(dout_eof), 128'(0));
    end
  endtask

  task automatic drive();
    logic [DW:0] w;
    bit has, mask;
    for (int i = 0; i < NS; i++) begin
      has  = (rp[i] < wp[i]);
      mask = rnd_ctl ? ($urandom_range(3) != 0) : 1'b1;
      src_req[i] = has && mask;
      if (src_grant[i] && has && !(stall_en && $urandom_range(3) == 0)) begin
        w = smem[i][rp[i]];
        rp[i]++;
        src_valid[i] = 1'b1;
        src_eof[i]   = w[DW];
        src_din[i*DW +: DW] = w[DW-1:0];
        last_eof_pop[i] = w[DW];
      end else begin
        src_valid[i] = noise_en && !src_grant[i] && ($urandom_range(1) == 1);
        src_eof[i]   = 1'($urandom_range(1));
        src_din[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (rnd_ctl) begin
      en       = ($urandom_range(7) != 0);
      tx_afull = ($urandom_range(3) == 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) monitor();
    prev_grant = src_grant;
    drive();
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < bound) begin
      step();
      n++;
      done = all_empty() && exp_q.size() == 0 && !busy && src_grant == '0;
    end
    chk(tag, 128'(done), 128'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush_model();
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 128'(src_grant), 128'(0));
    chk({tag, "_dout"}, dout, 128'(0));
    chk({tag, "_dout_valid"}, 128'(dout_valid), 128'(0));
    chk({tag, "_dout_eof"}, 128'(dout_eof), 128'(0));
    chk({tag, "_pkt_count"}, 128'(pkt_count), 128'(0));
    chk({tag, "_trunc_err"}, 128'(trunc_err), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; en = 1'b1; tx_afull = 1'b0;
    src_req = '0; src_valid = '0; src_eof = '0; src_din = '0;
    ifg_cycles = '0; max_len = '0;
    noise_en = 1'b0; stall_en = 1'b0; rnd_ctl = 1'b0;
    prev_grant = '0; vcnt = 0; pid = 0;
    for (int i = 0; i < NS; i++) begin wp[i] = 0; rp[i] = 0; end

    // Reset state
    do_reset();
    chk_all_zero("reset");

    // A: single source 0, 8 words, ifg=4, no stalls
    ifg_cycles = 32'd4;
    vcnt = 0;
    add_pkt(0, 8, 1'b0);
    step();
    step();
    chk("A_grant_latency", 128'(src_grant), 128'(4'b0001));
    n = 0;
    while (!dout_eof && n < 40) begin step(); n++; end
    chk("A_eof_latency", 128'(n), 128'(8));
    chk("A_words", 128'(vcnt), 128'(8));
    chk("A_pkt_count", 128'(pkt_count), 128'(1));
    n = 0;
    do begin step(); n++; end while (busy && n < 20);
    chk("A_gap_len", 128'(n), 128'(4));

    // B: all four sources request continuously, 3-word packets, ifg=0
    do_reset();
    ifg_cycles = 32'd0;
    stall_en = 1'b1;
    glog.delete();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < NS; s++) add_pkt(s, 3, 1'b0);
    wait_done("B_done", 400);
    for (int i = 0; i < 5; i++)
      chk("B_order", 128'((i < glog.size()) ? glog[i] : -1), 128'(i % NS));
    chk("B_pkt_count", 128'(pkt_count), 128'(8));

    // C: max_len=4 against a 10-word packet
    max_len = 16'd4;
    ifg_cycles = 32'd2;
    vcnt = 0;
    add_pkt(2, 10, 1'b0);
    wait_done("C_done", 200);
    chk("C_words", 128'(vcnt), 128'(4));
    chk("C_trunc", 128'(trunc_err), 128'(1));
    max_len = '0;

    // D: almost-full holds off the grant but not a packet in flight
    tx_afull = 1'b1;
    add_pkt(0, 6, 1'b0);
    repeat (5) step();
    chk("D_hold_grant", 128'(src_grant), 128'(0));
    chk("D_hold_busy", 128'(busy), 128'(0));
    tx_afull = 1'b0;
    step();
    chk("D_grant", 128'(src_grant), 128'(4'b0001));
    repeat (2) step();
    tx_afull = 1'b1;
    wait_done("D_done", 100);
    chk("D_pkt_count", 128'(pkt_count), 128'(exp_pkt));
    tx_afull = 1'b0;

    // E: non-granted sources toggle valid during a source 1 packet
    noise_en = 1'b1;
    vcnt = 0;
    add_pkt(1, 6, 1'b1);
    wait_done("E_done", 100);
    chk("E_words", 128'(vcnt), 128'(6));

    // F: reset in the middle of a packet (third word presented)
    noise_en = 1'b0;
    stall_en = 1'b0;
    vcnt = 0;
    add_pkt(2, 8, 1'b0);
    n = 0;
    while (vcnt < 2 && n < 20) begin step(); n++; end
    rst = 1'b1;
    flush_model();
    step();
    chk_all_zero("F_rst");
    rst = 1'b0;
    glog.delete();
    add_pkt(1, 3, 1'b0);
    add_pkt(0, 3, 1'b0);
    wait_done("F_done", 100);
    chk("F_first_grant", 128'((glog.size() > 0) ? glog[0] : -1), 128'(0));
    chk("F_pkt_count", 128'(pkt_count), 128'(2));

    // G: randomized packets, lengths, limits, gaps, en/afull/request jitter
    noise_en = 1'b1;
    stall_en = 1'b1;
    rnd_ctl  = 1'b1;
    for (int r = 0; r < 4; r++) begin
      max_len    = ($urandom_range(1) == 1) ? LW'($urandom_range(8, 3)) : '0;
      ifg_cycles = 32'($urandom_range(3, 0));
      for (int s = 0; s < NS; s++) begin
        n = $urandom_range(3, 1);
        for (int p = 0; p < n; p++) add_pkt(s, $urandom_range(12, 1), 1'b0);
      end
      wait_done("G_done", 3000);
      chk("G_pkt_count", 128'(pkt_count), 128'(exp_pkt));
      chk("G_trunc_err", 128'(trunc_err), 128'(exp_trunc));
    end
    rnd_ctl  = 1'b0;
    en       = 1'b1;
    tx_afull = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
